// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and requester indices for the register-file write arbiter.
package regfile_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int REG_ZERO = 0;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; last pointer moves only on a grant.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       hold_i,
  output logic [1:0] grant_o
);
  logic last_q, last_d;
  always_comb begin
    grant_o = hold_i ? 2'b00 : (&valid_i) ? (last_q ? 2'b01 : 2'b10) : valid_i;
    last_d = grant_o[REQ_MEM] ? 1'b1 : grant_o[REQ_ALU] ? 1'b0 : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port plus RAW scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH,
  parameter int NR = NUM_REGS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hold,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_reg,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_reg,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_reg,
  input  logic [AW-1:0] read_reg_1,
  input  logic [AW-1:0] read_reg_2,
  output logic          busy_1,
  output logic          busy_2,
  output logic          regwrite,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data
);
  logic [1:0] grant;
  logic acc;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] a_data;
  logic regwrite_q, regwrite_d;
  logic [AW-1:0] write_reg_q, write_reg_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic [NR-1:0] pending_q, pending_d;
  // Reset doubles as hold so neither requester sees ready while reset is high.
  rr_arbiter2 u_arb (
    .clk(clock),
    .rst(reset),
    .valid_i({req1_valid, req0_valid}),
    .hold_i(hold | reset),
    .grant_o(grant)
  );
  always_comb begin
    req0_ready = grant[REQ_ALU];
    req1_ready = grant[REQ_MEM];
    acc = |grant;
    a_reg = grant[REQ_MEM] ? req1_reg : req0_reg;
    a_data = grant[REQ_MEM] ? req1_data : req0_data;
    regwrite_d = acc & (a_reg != '0);
    write_reg_d = regwrite_d ? a_reg : write_reg_q;
    write_data_d = regwrite_d ? a_data : write_data_q;
    pending_d = pending_q;
    if (acc) pending_d[a_reg] = 1'b0;
    if (issue_valid) pending_d[issue_reg] = 1'b1;
    pending_d[REG_ZERO] = 1'b0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      write_reg_q <= '0;
      write_data_q <= '0;
      pending_q <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      write_reg_q <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q <= pending_d;
    end
  end
  // The in-flight write is still visible as busy until the register file commits it.
  always_comb begin
    regwrite = regwrite_q;
    write_reg = write_reg_q;
    write_data = write_data_q;
    busy_1 = (read_reg_1 != '0) & (pending_q[read_reg_1] | (regwrite_q & (write_reg_q == read_reg_1)));
    busy_2 = (read_reg_2 != '0) & (pending_q[read_reg_2] | (regwrite_q & (write_reg_q == read_reg_2)));
  end
endmodule
